sipo_comma_align: RTL and testbench

Receive-side deserializer for the SerDes RX path, the counterpart of the TX parallel-to-serial stage. It shifts in one serial bit per BitCLK and hunts for the K28.5 comma in either disparity at any bit offset. It locks 10-bit word boundaries to the comma and presents aligned 10-bit words to the downstream 8b/10b decoder. The serial line is LSB first: bit 0 of a 10-bit word ("a") is received first.

---
 rtl/sipo_comma_align.sv | 139 +++++++++++++
 tb/tb_sipo_comma_align.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_comma_align.sv
// Receive-side deserializer: shifts in the serial line LSB first, hunts for the
// K28.5 comma at any bit offset, locks word boundaries to it and emits aligned 10-bit words.
module sipo_comma_align #(
  parameter int         CONFIRM_CNT = 3,
  parameter int         LOSS_CNT    = 4,
  parameter logic [9:0] K_NEG       = 10'h17C,
  parameter logic [9:0] K_POS       = 10'h283
) (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic       Serial,
  output logic [9:0] RxParallel_10,
  output logic       RxValid,
  output logic       RxComma,
  output logic       RxAligned
);

  localparam int CW = (CONFIRM_CNT < 2) ? 1 : $clog2(CONFIRM_CNT + 1);
  localparam int MW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [CW-1:0] CONFIRM_TGT = CW'(CONFIRM_CNT);
  localparam logic [MW-1:0] LOSS_TGT    = MW'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT,
    CONFIRM,
    LOCKED
  } state_t;

  state_t          state;
  logic [9:0]      sr;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   confirm_cnt;
  logic [MW-1:0]   miss_cnt;

  logic [9:0]      win;
  logic            hit;
  logic            boundary;
  logic [3:0]      bit_cnt_next;
  logic [CW-1:0]   confirm_inc;
  logic [MW-1:0]   miss_inc;

  // win includes the bit being sampled on this edge, so a word is available
  // on the same edge that samples its last bit.
  assign win          = {Serial, sr[9:1]};
  assign hit          = (win == K_NEG) || (win == K_POS);
  assign boundary     = (bit_cnt == 4'd9) && (state != HUNT);
  assign bit_cnt_next = (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
  assign confirm_inc  = (confirm_cnt >= CONFIRM_TGT) ? confirm_cnt : confirm_cnt + CW'(1);
  assign miss_inc     = (miss_cnt >= LOSS_TGT) ? miss_cnt : miss_cnt + MW'(1);

  always_ff @(posedge BitCLK or posedge Reset) begin
    if (Reset) begin
      state         <= HUNT;
      sr            <= '0;
      bit_cnt       <= '0;
      confirm_cnt   <= '0;
      miss_cnt      <= '0;
      RxParallel_10 <= '0;
      RxValid       <= 1'b0;
      RxComma       <= 1'b0;
      RxAligned     <= 1'b0;
    end else begin
      sr      <= win;
      bit_cnt <= bit_cnt_next;
      RxValid <= 1'b0;
      RxComma <= 1'b0;

      case (state)
        HUNT: begin
          if (hit) begin
            RxParallel_10 <= win;
            RxValid       <= 1'b1;
            RxComma       <= 1'b1;
            bit_cnt       <= '0;
            confirm_cnt   <= CW'(1);
            if (CONFIRM_CNT <= 1) begin
              state     <= LOCKED;
              RxAligned <= 1'b1;
              miss_cnt  <= '0;
            end else begin
              state <= CONFIRM;
            end
          end
        end

        CONFIRM: begin
          if (boundary) begin
            RxParallel_10 <= win;
            RxValid       <= 1'b1;
            RxComma       <= hit;
            if (hit) begin
              confirm_cnt <= confirm_inc;
              if (confirm_inc >= CONFIRM_TGT) begin
                state     <= LOCKED;
                RxAligned <= 1'b1;
                miss_cnt  <= '0;
              end
            end
          end else if (hit) begin
            // A comma at a different offset restarts confirmation there.
            RxParallel_10 <= win;
            RxValid       <= 1'b1;
            RxComma       <= 1'b1;
            bit_cnt       <= '0;
            confirm_cnt   <= CW'(1);
          end
        end

        LOCKED: begin
          if (boundary) begin
            RxParallel_10 <= win;
            RxValid       <= 1'b1;
            RxComma       <= hit;
            if (hit) begin
              miss_cnt <= '0;
            end
          end else if (hit) begin
            miss_cnt <= miss_inc;
            // Too many stray commas: drop lock and realign on this one.
            if (miss_inc >= LOSS_TGT) begin
              state         <= CONFIRM;
              RxAligned     <= 1'b0;
              RxParallel_10 <= win;
              RxValid       <= 1'b1;
              RxComma       <= 1'b1;
              bit_cnt       <= '0;
              confirm_cnt   <= CW'(1);
            end
          end
        end

        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_comma_align.sv
// Scoreboard bench for sipo_comma_align: a bit-index reference model predicts
// every emitted word and the lock flag; a monitor compares on each clock.
module tb_sipo_comma_align;

  localparam int         CONFIRM_CNT = 3;
  localparam int         LOSS_CNT    = 4;
  localparam logic [9:0] K_NEG       = 10'h17C;
  localparam logic [9:0] K_POS       = 10'h283;

  logic       BitCLK = 1'b0;
  logic       Reset  = 1'b1;
  logic       Serial = 1'b0;
  logic [9:0] RxParallel_10;
  logic       RxValid;
  logic       RxComma;
  logic       RxAligned;

  always #5 BitCLK = ~BitCLK;

  sipo_comma_align #(
    .CONFIRM_CNT(CONFIRM_CNT),
    .LOSS_CNT   (LOSS_CNT),
    .K_NEG      (K_NEG),
    .K_POS      (K_POS)
  ) dut (
    .BitCLK       (BitCLK),
    .Reset        (Reset),
    .Serial       (Serial),
    .RxParallel_10(RxParallel_10),
    .RxValid      (RxValid),
    .RxComma      (RxComma),
    .RxAligned    (RxAligned)
  );

  typedef struct packed {
    logic [9:0] word;
    logic       comma;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: words are located by counting bits since the last
  // alignment point rather than by a wrapping counter.
  logic [9:0] m_win;
  int         m_mode;
  int         m_bit_idx;
  int         m_anchor;
  int         m_confirms;
  int         m_misses;
  logic       m_aligned;

  function automatic void modelReset();
    m_win      = '0;
    m_mode     = 0;
    m_bit_idx  = 0;
    m_anchor   = 0;
    m_confirms = 0;
    m_misses   = 0;
    m_aligned  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void modelEmit(input logic [9:0] w, input logic c);
    exp_t e;
    e.word  = w;
    e.comma = c;
    exp_q.push_back(e);
  endfunction

  function automatic void modelStep(input logic b);
    logic is_comma;
    logic on_word;
    m_bit_idx = m_bit_idx + 1;
    m_win     = {b, m_win[9:1]};
    is_comma  = (m_win == K_NEG) || (m_win == K_POS);
    on_word   = (m_mode != 0) && (m_bit_idx > m_anchor) && (((m_bit_idx - m_anchor) % 10) == 0);
    if (m_mode == 0) begin
      if (is_comma) begin
        modelEmit(m_win, 1'b1);
        m_anchor   = m_bit_idx;
        m_confirms = 1;
        m_mode     = 1;
      end
    end else if (on_word) begin
      modelEmit(m_win, is_comma);
      if (is_comma && m_mode == 1) begin
        m_confirms = m_confirms + 1;
        if (m_confirms >= CONFIRM_CNT) begin
          m_mode    = 2;
          m_aligned = 1'b1;
          m_misses  = 0;
        end
      end else if (is_comma) begin
        m_misses = 0;
      end
    end else if (is_comma) begin
      if (m_mode == 1) begin
        modelEmit(m_win, 1'b1);
        m_anchor   = m_bit_idx;
        m_confirms = 1;
      end else begin
        m_misses = m_misses + 1;
        if (m_misses >= LOSS_CNT) begin
          modelEmit(m_win, 1'b1);
          m_anchor   = m_bit_idx;
          m_confirms = 1;
          m_mode     = 1;
          m_aligned  = 1'b0;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a falling edge; drives one bit and returns at the next falling edge.
  task automatic applyStimulus(input logic b);
    Serial = b;
    modelStep(b);
    @(negedge BitCLK);
  endtask

  task automatic sendWord(input logic [9:0] w);
    for (int i = 0; i < 10; i++) applyStimulus(w[i]);
  endtask

  // Sends a bit, flipped if needed so the line never forms a comma.
  task automatic sendNonComma(input logic b);
    logic [9:0] nxt;
    logic       bb;
    bb  = b;
    nxt = {bb, m_win[9:1]};
    if (nxt == K_NEG || nxt == K_POS) bb = ~bb;
    applyStimulus(bb);
  endtask

  task automatic holdReset(input int cycles);
    Reset = 1'b1;
    modelReset();
    for (int i = 0; i < cycles; i++) begin
      Serial = 1'($urandom);
      @(negedge BitCLK);
    end
    Reset = 1'b0;
  endtask

  // Monitor: one sample per clock, just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge BitCLK);
      #1;
      checkOutput("aligned", 32'(RxAligned), 32'(m_aligned));
      checkOutput("comma_gating", 32'(RxComma & ~RxValid), 32'd0);
      if (RxValid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(RxValid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("word", 32'(RxParallel_10), 32'(e.word));
          checkOutput("comma", 32'(RxComma), 32'(e.comma));
        end
      end
      checkOutput("missing_valid", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  end

  initial begin
    int r;
    modelReset();
    @(negedge BitCLK);
    for (int i = 0; i < 4; i++) begin
      Serial = 1'($urandom);
      @(negedge BitCLK);
    end
    checkOutput("reset_word", 32'(RxParallel_10), 32'd0);
    checkOutput("reset_valid", 32'(RxValid), 32'd0);
    checkOutput("reset_comma", 32'(RxComma), 32'd0);
    checkOutput("reset_aligned", 32'(RxAligned), 32'd0);
    Reset = 1'b0;

    $display("[TB] random non-comma bits");
    for (int i = 0; i < 25; i++) sendNonComma(1'($urandom));
    checkOutput("no_lock_on_noise", 32'(RxAligned), 32'd0);

    $display("[TB] filler then comma/data sequence");
    for (int i = 0; i < 7; i++) sendNonComma(1'(i % 2));
    sendWord(10'h17C);
    sendWord(10'h2AA);
    sendWord(10'h283);
    sendWord(10'h155);
    sendWord(10'h17C);
    checkOutput("lock_after_three_commas", 32'(RxAligned), 32'd1);

    $display("[TB] one-bit slip while locked");
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) begin
      sendWord(10'h17C);
      sendWord(10'h2AA);
    end
    checkOutput("lock_holds_three_misses", 32'(RxAligned), 32'd1);
    sendWord(10'h17C);
    sendWord(10'h2AA);
    checkOutput("lock_lost_fourth_miss", 32'(RxAligned), 32'd0);
    sendWord(10'h17C);
    sendWord(10'h2AA);
    sendWord(10'h17C);
    checkOutput("relock_after_slip", 32'(RxAligned), 32'd1);

    $display("[TB] confirm restart on offset comma");
    @(negedge BitCLK);
    holdReset(3);
    sendWord(10'h17C);
    sendWord(10'h155);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    sendWord(10'h17C);
    sendWord(10'h155);
    sendWord(10'h17C);
    checkOutput("no_lock_two_at_new_offset", 32'(RxAligned), 32'd0);
    sendWord(10'h155);
    sendWord(10'h17C);
    checkOutput("lock_three_at_new_offset", 32'(RxAligned), 32'd1);

    $display("[TB] asynchronous reset mid-word");
    for (int i = 0; i < 5; i++) applyStimulus(1'(i % 2));
    @(posedge BitCLK);
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("async_word", 32'(RxParallel_10), 32'd0);
    checkOutput("async_valid", 32'(RxValid), 32'd0);
    checkOutput("async_aligned", 32'(RxAligned), 32'd0);
    modelReset();
    @(negedge BitCLK);
    holdReset(2);
    sendWord(10'h17C);
    sendWord(10'h2AA);
    sendWord(10'h17C);
    sendWord(10'h2AA);
    checkOutput("post_reset_two_commas", 32'(RxAligned), 32'd0);
    sendWord(10'h17C);
    checkOutput("post_reset_relock", 32'(RxAligned), 32'd1);

    $display("[TB] alternating disparity commas with 0F0");
    holdReset(2);
    for (int i = 0; i < 4; i++) begin
      sendWord(K_POS);
      sendWord(10'h0F0);
      sendWord(K_NEG);
      sendWord(10'h0F0);
    end
    checkOutput("lock_alternating", 32'(RxAligned), 32'd1);

    $display("[TB] randomized traffic with slips");
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        sendWord(($urandom_range(0, 1) == 0) ? K_NEG : K_POS);
      end else if (r < 9) begin
        sendWord(10'($urandom));
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 9)); k++) applyStimulus(1'($urandom));
      end
    end
    for (int i = 0; i < 3; i++) sendWord(10'h2AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
